// File: rtl/hwag_spi_pkg.sv
// Shared types and constants for the SPI-to-SSRAM bus master.
// Frame and bus FSM encodings plus the fixed frame geometry.
package hwag_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } frame_state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_WR,
    B_RD1,
    B_RD2,
    B_RD3
  } bus_state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_BITS     = 8;
  localparam int DUMMY_BITS    = 8;
  localparam int RD_CYCLES     = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall
// pulses; a pin edge shows up as a one-clk strobe three clk edges later.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= RESET_VAL;
      sync   <= RESET_VAL;
      sync_d <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
      fall   <= ~sync & sync_d;
    end
  end

endmodule

// File: rtl/spi_ssram_master.sv
// SPI mode-0 slave that converts host frames into single write or read
// cycles on the one-hot addressed SSRAM register bank.
module spi_ssram_master
  import hwag_spi_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [15:0]      row,
  output logic [15:0]      column,
  output logic             we,
  output logic             re,
  inout  wire  [WIDTH-1:0] data,
  output logic             busy
);

  localparam int CNT_W = $clog2((WIDTH > 8) ? WIDTH : 8);
  localparam logic [8:0] DEPTH_LIM = (DEPTH > 256) ? 9'd256 : 9'(DEPTH);

  frame_state_t frame_state, frame_next;
  bus_state_t   bus_state, bus_next;

  logic             sck_rise, sck_fall, cs_rise, cs_fall;
  logic             mosi_meta, mosi_s;
  logic [CNT_W-1:0] bit_cnt, last_idx;
  logic             bit_last;
  logic [WIDTH-2:0] sh_in;
  logic [WIDTH-1:0] shift_next;
  logic [7:0]       byte_next;
  logic             is_write;
  logic [7:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] out_sh;
  logic             rd_keep;
  logic             miso_q;
  logic             start_wr, start_rd;

  function automatic logic mapped(input logic [7:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sck),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign shift_next = {sh_in, mosi_s};
  assign byte_next  = shift_next[7:0];

  always_comb begin
    last_idx = CNT_W'(ADDR_BITS - 1);
    case (frame_state)
      DUMMY:   last_idx = CNT_W'(DUMMY_BITS - 1);
      DATA:    last_idx = CNT_W'(WIDTH - 1);
      default: last_idx = CNT_W'(ADDR_BITS - 1);
    endcase
  end

  assign bit_last = sck_rise && (bit_cnt == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_state <= IDLE;
    else     frame_state <= frame_next;
  end

  // cs_n edges override bit counting; sck edges outside a frame are ignored
  always_comb begin
    frame_next = frame_state;
    if (cs_fall) begin
      frame_next = CMD;
    end else if (cs_rise) begin
      frame_next = IDLE;
    end else if (bit_last) begin
      case (frame_state)
        CMD:     frame_next = ADDR;
        ADDR:    frame_next = is_write ? DATA : DUMMY;
        DUMMY:   frame_next = DATA;
        DATA:    frame_next = DONE;
        default: frame_next = frame_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      sh_in    <= '0;
      is_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (cs_fall || cs_rise) begin
        bit_cnt <= '0;
      end else if (sck_rise && frame_state inside {CMD, ADDR, DUMMY, DATA}) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + CNT_W'(1);
      end
      if (sck_rise && frame_state inside {CMD, ADDR, DATA})
        sh_in <= shift_next[WIDTH-2:0];
      if (bit_last && frame_state == CMD)
        is_write <= byte_next[CMD_WRITE_BIT];
      if (bit_last && frame_state == ADDR)
        addr_q <= byte_next;
      if (start_wr)
        wdata_q <= shift_next;
    end
  end

  // Reads launch as soon as the address is known so the bank pipeline
  // finishes inside the dummy byte; writes wait for the full data word.
  assign start_wr = bit_last && (frame_state == DATA) && is_write && mapped(addr_q);
  assign start_rd = bit_last && (frame_state == ADDR) && !is_write && mapped(byte_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_state <= B_IDLE;
    else     bus_state <= bus_next;
  end

  always_comb begin
    bus_next = bus_state;
    we       = 1'b0;
    re       = 1'b0;
    case (bus_state)
      B_IDLE: begin
        if (start_wr)      bus_next = B_WR;
        else if (start_rd) bus_next = B_RD1;
      end
      B_WR: begin
        we       = 1'b1;
        bus_next = B_IDLE;
      end
      B_RD1: begin
        re       = 1'b1;
        bus_next = B_RD2;
      end
      B_RD2: begin
        re       = 1'b1;
        bus_next = B_RD3;
      end
      B_RD3: begin
        re       = 1'b1;
        bus_next = B_IDLE;
      end
      default: bus_next = B_IDLE;
    endcase
  end

  assign row    = (we || re) ? (16'h0001 << addr_q[7:4]) : 16'h0000;
  assign column = (we || re) ? (16'h0001 << addr_q[3:0]) : 16'h0000;
  assign data   = we ? wdata_q : {WIDTH{1'bz}};

  // A read whose frame was aborted still runs on the bus but loads zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_keep <= 1'b0;
      out_sh  <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (start_rd)     rd_keep <= 1'b1;
      else if (cs_rise) rd_keep <= 1'b0;

      if (cs_fall) begin
        out_sh <= '0;
        miso_q <= 1'b0;
      end else if (bus_state == B_RD3) begin
        out_sh <= rd_keep ? data : '0;
      end else if (sck_fall) begin
        if (frame_state == DATA && !is_write) begin
          miso_q <= out_sh[WIDTH-1];
          out_sh <= {out_sh[WIDTH-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
      if (cs_rise) miso_q <= 1'b0;
    end
  end

  assign miso = miso_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= cs_fall || (frame_state != IDLE) || (bus_state != B_IDLE);
  end

endmodule

// File: doc/spi_ssram_master.md
# spi_ssram_master

SPI-slave front end that turns serial frames from the host MCU into single register-bank bus cycles on the one-hot-addressed SSRAM register bank. It decodes an 8-bit address into row/column one-hot selects, sequences `we`/`re` with the bank's two-stage read-enable delay, and drives or samples the shared tri-state data bus. It is the only master of that bus and sits directly upstream of the register bank.

## Interface
- `WIDTH`, 16: data word width; the bank's data bus width.
- `DEPTH`, 256: number of implemented registers. Addresses ≥ DEPTH are unmapped.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sck` in 1: SPI clock, mode 0, asynchronous to `clk`.
- `cs_n` in 1: SPI chip select, active low, asynchronous.
- `mosi` in 1: SPI data in, MSB first.
- `miso` out 1: SPI data out, MSB first. Driven 0 when not shifting read data.
- `row` out 16: one-hot row select, `row[addr[7:4]]`.
- `column` out 16: one-hot column select, `column[addr[3:0]]`.
- `we` out 1: bank write strobe.
- `re` out 1: bank read enable.
- `data` inout WIDTH: bank data bus. Driven only while `we`=1; high-Z otherwise.
- `busy` out 1: high from frame start (`cs_n` fall) until the bus FSM returns to idle.

## Operation
- Input conditioning: `sck`, `cs_n`, `mosi` each pass a 2-FF synchronizer. `sck` rise/fall and `cs_n` fall/rise are detected from the synchronized signals. Host requirement: each `sck` phase lasts ≥4 `clk` periods.
- Write frame: cmd byte with bit7=1 (bits 6:0 ignored), then addr byte, then WIDTH data bits.
- Read frame: cmd byte with bit7=0, then addr byte, then 8 dummy `sck` cycles, then WIDTH data bits shifted out on `miso`. `mosi` is ignored after the address.
- Bits are sampled on synchronized `sck` rise. `miso` changes on synchronized `sck` fall. The first read bit is presented at the fall following the last dummy bit.
- Frame FSM states: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
  - `cs_n` fall: enter CMD.
  - CMD → ADDR after 8 bits.
  - ADDR → DATA (write) or DUMMY (read) after 8 bits.
  - DUMMY → DATA after 8 bits.
  - DATA → DONE after WIDTH bits.
  - DONE: extra `sck` edges are ignored; return to IDLE on `cs_n` rise.
- Bus FSM states: B_IDLE, B_WR, B_RD1, B_RD2, B_RD3.
  - Write: on DATA completion, go to B_WR for exactly 1 `clk` with `row`/`column` decoded, `data` driven with the word, and `we`=1. Then return to B_IDLE with selects cleared.
  - Read: on ADDR completion, selects are applied and `re`=1 for B_RD1..B_RD3 (3 `clk`). `data` is captured into the shift register at the end of B_RD3, i.e. after the bank's two registered read-enable stages. Then `re`=0, selects cleared, back to B_IDLE.
- Unmapped address (≥ DEPTH): no bus cycle is issued (`we`, `re`, selects stay 0). A read returns all zeros.
- Abort: `cs_n` rise before DONE returns the frame FSM to IDLE immediately.
  - Partial write frame: no `we` is ever issued.
  - Read bus cycle already in progress: it completes, but the result is discarded and `miso` returns to 0.
- `cs_n` fall while `busy` (back-to-back frames): the new frame starts. An in-progress bus cycle still completes first, which the ≥4-`clk` `sck` rule guarantees before the next address completes.

## Timing
- Reset values: `row`=0, `column`=0, `we`=0, `re`=0, `data`=Z, `miso`=0, `busy`=0. Both FSMs go to IDLE and the shift registers clear.
- Reset mid-frame: immediate return to reset state. The host frame is lost.
- Synchronizer plus edge-detect latency: 3 `clk` from pin edge to internal strobe.
- Write: `we` asserts 1 `clk` after the internal strobe of the last data bit. Selects and `data` are valid in that same cycle.
- Read: `re` asserts 1 `clk` after the internal strobe of the last address bit. Capture happens 3 `clk` later, well within the dummy window.
- `busy` falls 1 `clk` after B_IDLE is reached with the frame FSM in IDLE.

## Structure
- Shared package `hwag_spi_pkg`:
  - `frame_state_t` and `bus_state_t` enums.
  - `CMD_WRITE_BIT`=7, `ADDR_BITS`=8, `DUMMY_BITS`=8, `RD_CYCLES`=3.
- Sub-module `spi_sync_edge`: 2-FF synchronizer with rise/fall pulse outputs, instantiated for `sck` and `cs_n`. `mosi` uses plain 2-FF synchronization.

## Test plan
- Write frame cmd 0x80, addr 0x35, data 0xBEEF → exactly one `clk` with `we`=1, `row`=0x0008, `column`=0x0020, `data`=0xBEEF. The bank's register 0x35 reads 0xBEEF afterwards.
- Read frame cmd 0x00, addr 0x35 (preloaded 0xBEEF) → `re` high for exactly 3 `clk`; `miso` shifts out 0xBEEF MSB first after the dummy byte.
- Write to addr 0xFF with DEPTH=200 → no `we`. A read of 0xFF returns 0x0000 with `re` never asserted.
- `cs_n` raised after 4 data bits of a write frame → no `we`, `busy` drops, and the next full frame works normally.
- `rst` asserted during B_RD2 → `re`, `row`, `column` go to 0 and `data` to high-Z asynchronously; `miso`=0 and `busy`=0.
- Two back-to-back frames, write 0x1234 to 0x01 then read 0x01, with minimal `cs_n` high time (≥4 `clk`) → the read returns 0x1234.
